// File: rtl/conv_pool_pkg.sv
// Shared constants for the conv/pool control sequencer: state codes, tap
// strobes, map geometry and memory region bases.
package conv_pool_pkg;

    localparam int unsigned IMG_W       = 8;
    localparam int unsigned CONV_N      = 7;
    localparam int unsigned POOL_N      = 3;
    localparam int unsigned POOL_STRIDE = 2;

    localparam int unsigned CW      = 4;   // row/col width
    localparam int unsigned PIX_W   = 7;   // pixel index width
    localparam int unsigned STATE_W = 3;

    localparam int unsigned CONV_BASE = 64;
    localparam int unsigned POOL_BASE = 128;

    localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] ST_LD0  = 3'd1;
    localparam logic [STATE_W-1:0] ST_LD1  = 3'd2;
    localparam logic [STATE_W-1:0] ST_LD2  = 3'd3;
    localparam logic [STATE_W-1:0] ST_LD3  = 3'd4;
    localparam logic [STATE_W-1:0] ST_CALC = 3'd5;
    localparam logic [STATE_W-1:0] ST_WR   = 3'd6;
    localparam logic [STATE_W-1:0] ST_DONE = 3'd7;

    localparam logic [3:0] LOAD_T0 = 4'b1000;  // +0
    localparam logic [3:0] LOAD_T1 = 4'b0100;  // +1
    localparam logic [3:0] LOAD_T2 = 4'b0010;  // +IMG_W
    localparam logic [3:0] LOAD_T3 = 4'b0001;  // +IMG_W+1

    localparam logic [CW-1:0] CONV_STEP = CW'(1);
    localparam logic [CW-1:0] CONV_LIM  = CW'(CONV_N - 1);
    localparam logic [CW-1:0] POOL_STEP = CW'(POOL_STRIDE);
    localparam logic [CW-1:0] POOL_LIM  = CW'((POOL_N - 1) * POOL_STRIDE);

    // Linear pixel index: 8-bit product/sum, low PIX_W bits kept.
    function automatic logic [PIX_W-1:0] pixel_of(input logic [CW-1:0] r,
                                                  input logic [CW-1:0] c);
        logic [7:0] p;
        p = 8'(r) * 8'(IMG_W) + 8'(c);
        return p[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/conv_pool_seq_pos_counter.sv
// Row/col stepper: advances by 'step' along a row up to 'limit', then wraps
// to the next row; returns to (0,0) after the last position.
module pos_counter
    import conv_pool_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          step_en,
    input  logic [CW-1:0] step,
    input  logic [CW-1:0] limit,
    output logic [CW-1:0] row,
    output logic [CW-1:0] col,
    output logic [CW-1:0] nxt_row_c,
    output logic [CW-1:0] nxt_col_c,
    output logic          last_c
);

    // Next position and end-of-grid detect
    always_comb begin
        last_c    = (row == limit) && (col == limit);
        nxt_row_c = row;
        nxt_col_c = col;
        if (clr) begin
            nxt_row_c = '0;
            nxt_col_c = '0;
        end else if (step_en) begin
            if (last_c) begin
                nxt_row_c = '0;
                nxt_col_c = '0;
            end else if (col < limit) begin
                nxt_col_c = CW'(col + step);
            end else begin
                nxt_col_c = '0;
                nxt_row_c = CW'(row + step);
            end
        end
    end

    // Position register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else begin
            row <= nxt_row_c;
            col <= nxt_col_c;
        end
    end

endmodule

// File: rtl/conv_pool_seq.sv
// Conv/pool control sequencer: walks a 7x7 conv grid then a 3x3 stride-2
// pool grid, six cycles per position (LD0..LD3, CALC, WR).
// Optional build macro CONV_POOL_SEQ_STALL_EN adds mem_rdy back-pressure on
// the load and write states.
module conv_pool_seq
    import conv_pool_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
`ifdef CONV_POOL_SEQ_STALL_EN
    input  logic             mem_rdy,
`endif
    input  logic             start,
    output logic [CW-1:0]    col,
    output logic [CW-1:0]    row,
    output logic [PIX_W-1:0] pixel,
    output logic             c_p,
    output logic [3:0]       load,
    output logic             write,
    output logic             en,
    output logic             acc_clr,
    output logic             busy,
    output logic             done
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic               cp_nxt;
    logic               step_c;
    logic               rdy_c;
    logic               last_c;
    logic [CW-1:0]      step_sel;
    logic [CW-1:0]      lim_sel;
    logic [CW-1:0]      nxt_row_c;
    logic [CW-1:0]      nxt_col_c;
    logic [3:0]         load_d;
    logic               write_d;
    logic               en_d;
    logic               acc_clr_d;
    logic               done_d;

`ifdef CONV_POOL_SEQ_STALL_EN
    assign rdy_c = mem_rdy;
`else
    assign rdy_c = 1'b1;
`endif

    assign step_sel = c_p ? POOL_STEP : CONV_STEP;
    assign lim_sel  = c_p ? POOL_LIM  : CONV_LIM;

    pos_counter u_pos (
        .clk       (clk),
        .rst       (rst),
        .clr       (state == ST_IDLE),
        .step_en   (step_c),
        .step      (step_sel),
        .limit     (lim_sel),
        .row       (row),
        .col       (col),
        .nxt_row_c (nxt_row_c),
        .nxt_col_c (nxt_col_c),
        .last_c    (last_c)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state, phase and next-cycle output decode
    always_comb begin
        state_nxt = state;
        cp_nxt    = c_p;
        step_c    = 1'b0;
        unique case (state)
            ST_IDLE: if (start) begin
                state_nxt = ST_LD0;
                cp_nxt    = 1'b0;
            end
            ST_LD0:  if (rdy_c) state_nxt = ST_LD1;
            ST_LD1:  if (rdy_c) state_nxt = ST_LD2;
            ST_LD2:  if (rdy_c) state_nxt = ST_LD3;
            ST_LD3:  if (rdy_c) state_nxt = ST_CALC;
            ST_CALC: state_nxt = ST_WR;
            ST_WR: if (rdy_c) begin
                step_c = 1'b1;
                if (last_c && c_p) begin
                    state_nxt = ST_DONE;
                    cp_nxt    = 1'b0;
                end else begin
                    state_nxt = ST_LD0;
                    if (last_c) cp_nxt = 1'b1;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase

        load_d    = 4'b0000;
        unique case (state_nxt)
            ST_LD0:  load_d = LOAD_T0;
            ST_LD1:  load_d = LOAD_T1;
            ST_LD2:  load_d = LOAD_T2;
            ST_LD3:  load_d = LOAD_T3;
            default: load_d = 4'b0000;
        endcase
        write_d   = (state_nxt == ST_WR);
        en_d      = (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
        acc_clr_d = (state_nxt == ST_LD0);
        done_d    = (state_nxt == ST_DONE);
    end

    // Registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel   <= '0;
            c_p     <= 1'b0;
            load    <= 4'b0000;
            write   <= 1'b0;
            en      <= 1'b0;
            acc_clr <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            pixel   <= pixel_of(nxt_row_c, nxt_col_c);
            c_p     <= cp_nxt;
            load    <= load_d;
            write   <= write_d;
            en      <= en_d;
            acc_clr <= acc_clr_d;
            busy    <= en_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_conv_pool_seq.sv
// Self-checking bench for conv_pool_seq: per-cycle scoreboard of a reference
// walk, a checkpoint table over the first pass, reset and restart sequences.
module tb_conv_pool_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
`ifdef CONV_POOL_SEQ_STALL_EN
    logic       mem_rdy;
`endif
    logic [3:0] col;
    logic [3:0] row;
    logic [6:0] pixel;
    logic       c_p;
    logic [3:0] load;
    logic       write;
    logic       en;
    logic       acc_clr;
    logic       busy;
    logic       done;

    conv_pool_seq dut (
        .clk     (clk),
        .rst     (rst),
`ifdef CONV_POOL_SEQ_STALL_EN
        .mem_rdy (mem_rdy),
`endif
        .start   (start),
        .col     (col),
        .row     (row),
        .pixel   (pixel),
        .c_p     (c_p),
        .load    (load),
        .write   (write),
        .en      (en),
        .acc_clr (acc_clr),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] col;
        logic [3:0] row;
        logic [6:0] pix;
        logic       cp;
        logic [3:0] load;
        logic       wr;
        logic       en;
        logic       clr;
        logic       busy;
        logic       done;
    } out_t;

    typedef struct {
        int    idx;
        out_t  exp;
        string name;
    } vec_t;

    out_t cur;
    assign cur = {col, row, pixel, c_p, load, write, en, acc_clr, busy, done};

    out_t exp_q[$];
    out_t act_log[0:399];
    vec_t tbl[15];
    out_t zero;
    int   checks = 0;
    int   errors = 0;

    function automatic out_t mk(input int c, input int r, input int p, input bit cp,
                                input logic [3:0] ld, input bit wr, input bit e,
                                input bit clr, input bit b, input bit d);
        out_t o;
        o.col = 4'(c); o.row = 4'(r); o.pix = 7'(p); o.cp = cp; o.load = ld;
        o.wr = wr; o.en = e; o.clr = clr; o.busy = b; o.done = d;
        return o;
    endfunction

    task automatic check(input string name, input out_t act, input out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference walk: conv 7x7 step 1, then pool 3x3 step 2, DONE, IDLE.
    task automatic build(input int stall_len);
        int lim, st;
        bit first;
        logic [3:0] ld;
        first = 1'b1;
        for (int ph = 0; ph < 2; ph++) begin
            lim = (ph == 0) ? 6 : 4;
            st  = (ph == 0) ? 1 : 2;
            for (int r = 0; r <= lim; r += st) begin
                for (int c = 0; c <= lim; c += st) begin
                    for (int t = 0; t < 6; t++) begin
                        ld = 4'b1000;
                        ld = (t < 4) ? (ld >> t) : 4'b0000;
                        exp_q.push_back(mk(c, r, r*8 + c, ph[0], ld, t == 5, 1'b1,
                                           t == 0, 1'b1, 1'b0));
                        if (first && t == 1)
                            for (int s = 0; s < stall_len; s++)
                                exp_q.push_back(exp_q[$]);
                    end
                    first = 1'b0;
                end
            end
        end
        exp_q.push_back(mk(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 1));
        exp_q.push_back(mk(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0));
    endtask

    // Launch a pass from a negedge and compare every cycle until the queue drains.
    task automatic run_pass(input int stall_len, input int abort_idx,
                            input int start_a, input int start_b, input bit log_en);
        int   k;
        out_t e;
        build(stall_len);
        start = 1'b1;
        k = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("sb_cycle_%0d", k), cur, e);
            if (log_en && k < 400) act_log[k] = cur;
            start = (k == start_a) || (k == start_b);
`ifdef CONV_POOL_SEQ_STALL_EN
            mem_rdy = !(k >= 1 && k <= stall_len);
`endif
            if (k == abort_idx) begin
                #1 rst = 1'b1;
                #1 check("async_rst", cur, zero);
                exp_q.delete();
                @(negedge clk);
                check("rst_hold", cur, zero);
                rst = 1'b0;
            end
            k++;
        end
        start = 1'b0;
    endtask

    initial begin
        zero  = '0;
        rst   = 1'b1;
        start = 1'b0;
`ifdef CONV_POOL_SEQ_STALL_EN
        mem_rdy = 1'b1;
`endif
        tbl[0]  = '{0,   mk(0,0,0, 0,4'b1000,0,1,1,1,0), "ld0_first"};
        tbl[1]  = '{1,   mk(0,0,0, 0,4'b0100,0,1,0,1,0), "ld1_first"};
        tbl[2]  = '{2,   mk(0,0,0, 0,4'b0010,0,1,0,1,0), "ld2_first"};
        tbl[3]  = '{3,   mk(0,0,0, 0,4'b0001,0,1,0,1,0), "ld3_first"};
        tbl[4]  = '{4,   mk(0,0,0, 0,4'b0000,0,1,0,1,0), "calc_first"};
        tbl[5]  = '{5,   mk(0,0,0, 0,4'b0000,1,1,0,1,0), "wr_first"};
        tbl[6]  = '{36,  mk(6,0,6, 0,4'b1000,0,1,1,1,0), "conv_0_6"};
        tbl[7]  = '{42,  mk(0,1,8, 0,4'b1000,0,1,1,1,0), "row_wrap"};
        tbl[8]  = '{288, mk(6,6,54,0,4'b1000,0,1,1,1,0), "conv_last"};
        tbl[9]  = '{294, mk(0,0,0, 1,4'b1000,0,1,1,1,0), "phase_switch"};
        tbl[10] = '{300, mk(2,0,2, 1,4'b1000,0,1,1,1,0), "pool_col2"};
        tbl[11] = '{342, mk(4,4,36,1,4'b1000,0,1,1,1,0), "pool_last"};
        tbl[12] = '{347, mk(4,4,36,1,4'b0000,1,1,0,1,0), "pool_last_wr"};
        tbl[13] = '{348, mk(0,0,0, 0,4'b0000,0,0,0,0,1), "done_pulse"};
        tbl[14] = '{349, mk(0,0,0, 0,4'b0000,0,0,0,0,0), "idle_after"};

        repeat (2) @(negedge clk);
        check("reset_state", cur, zero);
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_start", cur, zero);

        // Full pass with stray starts mid-conv and during DONE
        run_pass(0, -1, 100, 348, 1'b1);
        for (int i = 0; i < 15; i++)
            check(tbl[i].name, act_log[tbl[i].idx], tbl[i].exp);
        @(negedge clk);
        check("idle_hold", cur, zero);

        // Reset in LD2 of pool (2,2), then a fresh pass from conv (0,0)
        run_pass(0, 320, -1, -1, 1'b0);
        @(negedge clk);
        check("post_rst_idle", cur, zero);
        run_pass(0, -1, -1, -1, 1'b0);

`ifdef CONV_POOL_SEQ_STALL_EN
        // Three stall cycles in the first LD1 stretch the pass to 351
        run_pass(3, -1, -1, -1, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
